// File: rtl/imem_loader.sv
// imem_loader: write-side controller for the LEGv8 instruction memory.
// Muxes the memory address between the CPU fetch port and a byte-stream
// program loader. Bytes are assembled little-endian into 32-bit words,
// written from address 0, and the remainder of the memory is filled with NOPs.
// The core is held in stall for the entire load.
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  output logic          cpu_stall,
  output logic          load_done
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;

  // Length is compared on AW+1 bits so that a full-depth load terminates.
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [1:0]    bcnt;
  logic [N-1:0]  word;
  logic [AW:0]   len;

  // Requested lengths above the memory depth are clamped to the depth.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  // Control FSM: sequences byte reception, word writes, NOP fill and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wptr  <= '0;
      bcnt  <= '0;
      word  <= '0;
      len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            len   <= clamp_len(load_len);
            wptr  <= '0;
            bcnt  <= '0;
            state <= (load_len != '0) ? RECV : FILL;
          end
        end
        RECV: begin
          if (byte_valid) begin
            word[{bcnt, 3'b000} +: 8] <= byte_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          wptr <= wptr + AW'(1);
          if (({1'b0, wptr} + (AW+1)'(1)) == len)
            state <= (len < DEPTH_L) ? FILL : DONE;
          else
            state <= RECV;
        end
        FILL: begin
          wptr <= wptr + AW'(1);
          if (wptr == LAST_A) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from the registered state; the address follows
  // the CPU only while idle so fetches are undisturbed between loads.
  always_comb begin
    byte_ready = (state == RECV);
    mem_we     = (state == WRITE) || (state == FILL);
    mem_wdata  = (state == WRITE) ? word : '0;
    mem_addr   = (state == IDLE) ? pc_addr : wptr;
    cpu_stall  = (state != IDLE);
    load_done  = (state == DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes the expected memory
// write/done sequence for each load; a monitor pops and compares.
module tb_imem_loader;
  logic        clk = 0;
  logic        reset;
  logic [5:0]  pc_addr;
  logic        load_start;
  logic [6:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        load_done;

  imem_loader dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .load_start(load_start),
    .load_len(load_len), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {bit done; logic [5:0] addr; logic [31:0] data;} ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] words [64];
  int gap_fixed = -1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done pulse must match the queue head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && (mem_we || load_done)) begin
        chk("we_and_done_exclusive", {31'd0, mem_we & load_done}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {31'd0, mem_we}, {31'd0, ~load_done});
          chk("unexpected_event_present", 32'd1, {31'd0, 1'b0});
        end else begin
          e = exp_q.pop_front();
          chk("event_is_done", {31'd0, load_done}, {31'd0, e.done});
          if (!e.done) begin
            chk("write_addr", {26'd0, mem_addr}, {26'd0, e.addr});
            chk("write_data", mem_wdata, e.data);
          end
        end
      end
    end
  end

  task automatic start_load(input int len);
    @(posedge clk); #1;
    load_start = 1; load_len = 7'(len);
    @(posedge clk); #1;
    load_start = 0; load_len = 7'($urandom_range(0, 127));
    @(negedge clk);
    chk("stall_after_start", {31'd0, cpu_stall}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    gap = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(0, 2));
    repeat (gap) begin
      @(posedge clk); #1;
      pc_addr = 6'($urandom);
      @(negedge clk);
      // No write may occur while the loader is idle between bytes
      if (mem_we) chk("write_during_gap", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    byte_valid = 1; byte_data = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    byte_valid = 0; byte_data = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("load_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("stall_released", {31'd0, cpu_stall}, 32'd0);
    chk("addr_follows_pc", {26'd0, mem_addr}, {26'd0, pc_addr});
  endtask

  // Reference: len words of data from address 0, zeros to the top, then done.
  task automatic expect_load(input int len);
    int eff;
    ev_t e;
    eff = (len > 64) ? 64 : len;
    for (int a = 0; a < 64; a++) begin
      e.done = 0; e.addr = 6'(a);
      e.data = (a < eff) ? words[a] : 32'd0;
      exp_q.push_back(e);
    end
    e.done = 1; e.addr = 0; e.data = 0;
    exp_q.push_back(e);
  endtask

  task automatic run_load(input int len, input bit mid_pulse);
    int eff;
    eff = (len > 64) ? 64 : len;
    expect_load(len);
    start_load(len);
    for (int i = 0; i < eff; i++) begin
      if (mid_pulse && i == 1) begin
        send_byte(words[i][7:0]);
        @(posedge clk); #1;
        load_start = 1; load_len = 7'd10;
        @(posedge clk); #1;
        load_start = 0;
        for (int k = 1; k < 4; k++) send_byte(words[i][8*k +: 8]);
      end else begin
        send_word(words[i]);
      end
    end
    wait_done();
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1; pc_addr = 6'd5; load_start = 0; load_len = 0;
    byte_valid = 0; byte_data = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    // Reset / idle state
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd5);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // Single word then 63 NOP fills
    gap_fixed = 0;
    words[0] = 32'h8b00001e;
    run_load(1, 0);

    // Two words with 3-cycle gaps between bytes
    gap_fixed = 3;
    words[0] = 32'h8b00001e; words[1] = 32'h91003c0a;
    run_load(2, 0);

    // Full-depth load, then zero-length load
    gap_fixed = -1;
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    run_load(64, 0);
    run_load(0, 0);

    // Reset in the middle of word 1
    gap_fixed = 0;
    words[0] = $urandom; words[1] = $urandom;
    begin
      ev_t e;
      e.done = 0; e.addr = 0; e.data = words[0];
      exp_q.push_back(e);
    end
    start_load(3);
    send_word(words[0]);
    send_byte(words[1][7:0]);
    send_byte(words[1][15:8]);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; pc_addr = 6'd42;
    @(negedge clk);
    chk("midrst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("midrst_addr", {26'd0, mem_addr}, 32'd42);
    chk("midrst_queue", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 pc_addr = 6'($urandom); byte_valid = 1; byte_data = 8'($urandom);
      @(negedge clk);
      chk("idle_addr_tracks_pc", {26'd0, mem_addr}, {26'd0, pc_addr});
      chk("idle_no_ready", {31'd0, byte_ready}, 32'd0);
    end
    @(posedge clk); #1 byte_valid = 0;

    // load_start during RECV is ignored
    gap_fixed = -1;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_load(3, 1);

    // Randomized lengths, including requests above the depth
    for (int r = 0; r < 4; r++) begin
      int l;
      l = (r == 0) ? 100 : int'($urandom_range(0, 70));
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      run_load(l, 0);
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
